// File: rtl/key_fetch_pkg.sv
// key_fetch_pkg: shared FSM encoding, requester IDs and ROM geometry for key_fetch_ctrl
package key_fetch_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;
    localparam logic REQ_ATT = 1'b0;
    localparam logic REQ_CPU = 1'b1;
    function automatic int key_words(input int mem_size);
        return mem_size / 2;
    endfunction
endpackage

// File: rtl/key_fetch_ctrl_if.sv
// key_fetch_ctrl_if: request and key-stream handshake bundle between requesters and key_fetch_ctrl
interface key_fetch_ctrl_if #(parameter int ADDR_MSB = 4);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [ADDR_MSB:0] req0_offset;
    logic [ADDR_MSB:0] req1_offset;
    logic [ADDR_MSB:0] req0_len;
    logic [ADDR_MSB:0] req1_len;
    logic [1:0]        key_valid;
    logic [1:0]        key_ready;
    logic              key_last;
    logic [1:0]        key_err;
    logic [15:0]       key_data;
    modport master (
        output req_valid, req0_offset, req1_offset, req0_len, req1_len, key_ready,
        input  req_ready, key_valid, key_last, key_err, key_data
    );
    modport slave (
        input  req_valid, req0_offset, req1_offset, req0_len, req1_len, key_ready,
        output req_ready, key_valid, key_last, key_err, key_data
    );
endinterface

// File: rtl/key_req_check.sv
// key_req_check: fixed-priority grant plus range/permission check of the granted request
module key_req_check
    import key_fetch_pkg::*;
#(
    parameter int ADDR_MSB  = 4,
    parameter int KEY_WORDS = 10
) (
    input  logic [1:0]        req_valid,
    input  logic [ADDR_MSB:0] req0_offset,
    input  logic [ADDR_MSB:0] req1_offset,
    input  logic [ADDR_MSB:0] req0_len,
    input  logic [ADDR_MSB:0] req1_len,
    input  logic              att_active,
    output logic              grant,
    output logic              grant_idx,
    output logic [ADDR_MSB:0] offset,
    output logic [ADDR_MSB:0] len,
    output logic              reject
);
    localparam logic [ADDR_MSB+1:0] KW = (ADDR_MSB+2)'(KEY_WORDS);
    logic [ADDR_MSB+1:0] sum;
    always_comb begin
        grant     = |req_valid;
        grant_idx = req_valid[0] ? REQ_ATT : REQ_CPU;
        offset    = grant_idx ? req1_offset : req0_offset;
        len       = grant_idx ? req1_len : req0_len;
        // one extra bit so offset+len never wraps back into range
        sum       = {1'b0, offset} + {1'b0, len};
        reject    = (len == '0) || (sum > KW) || (grant_idx == REQ_CPU && !att_active);
    end
endmodule

// File: rtl/key_fetch_ctrl.sv
// key_fetch_ctrl: arbitrates two requesters onto the key ROM and streams checked key bursts
module key_fetch_ctrl
    import key_fetch_pkg::*;
#(
    parameter int ADDR_MSB = 4,
    parameter int MEM_SIZE = 20
) (
    input  logic              mclk,
    input  logic              reset_n,
    input  logic              att_active,
    key_fetch_ctrl_if.slave   bus,
    output logic [ADDR_MSB:0] rom_addr,
    output logic              rom_cen,
    input  logic [15:0]       rom_dout
);
    localparam int KEY_WORDS = key_words(MEM_SIZE);
    logic [1:0]        state;
    logic              k;
    logic [ADDR_MSB:0] offset;
    logic [ADDR_MSB:0] len;
    logic [ADDR_MSB:0] idx;
    logic              grant;
    logic              grant_idx;
    logic [ADDR_MSB:0] sel_offset;
    logic [ADDR_MSB:0] sel_len;
    logic              reject;
    logic              abort;
    logic              last;
    logic              fire;
    logic [1:0]        valid;

    key_req_check #(.ADDR_MSB(ADDR_MSB), .KEY_WORDS(KEY_WORDS)) u_check (
        .req_valid   (bus.req_valid),
        .req0_offset (bus.req0_offset),
        .req1_offset (bus.req1_offset),
        .req0_len    (bus.req0_len),
        .req1_len    (bus.req1_len),
        .att_active  (att_active),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .offset      (sel_offset),
        .len         (sel_len),
        .reject      (reject)
    );

    always_comb begin
        // CPU access is revoked combinationally the moment the attestation region is left
        abort         = k == REQ_CPU && !att_active && (state == ST_READ || state == ST_DATA);
        last          = idx == len - 1'b1;
        valid         = (state == ST_DATA && !abort) ? 2'b01 << k : 2'b00;
        fire          = |(valid & bus.key_ready);
        bus.req_ready = (state == ST_IDLE && grant) ? 2'b01 << grant_idx : 2'b00;
        bus.key_valid = valid;
        bus.key_last  = |valid && last;
        bus.key_data  = |valid ? rom_dout : 16'h0000;
        bus.key_err   = state == ST_ERR ? 2'b01 << k : 2'b00;
        rom_cen       = !(state == ST_READ && !abort);
        rom_addr      = state == ST_READ ? offset + idx : '0;
    end

    always_ff @(posedge mclk) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            k      <= REQ_ATT;
            offset <= '0;
            len    <= '0;
            idx    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (grant) begin
                    k      <= grant_idx;
                    offset <= sel_offset;
                    len    <= sel_len;
                    idx    <= '0;
                    state  <= reject ? ST_ERR : ST_READ;
                end
                ST_READ: state <= abort ? ST_ERR : ST_DATA;
                ST_DATA: if (abort) begin
                    state <= ST_ERR;
                end else if (fire) begin
                    state <= last ? ST_IDLE : ST_READ;
                    idx   <= idx + 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_fetch_ctrl.sv
// tb_key_fetch_ctrl: table vectors, corner sequences and randomized requests against a word-level model
`timescale 1ns/1ps
module tb_key_fetch_ctrl;
    logic        mclk = 1'b0;
    logic        reset_n;
    logic        att_active;
    logic [4:0]  rom_addr;
    logic        rom_cen;
    logic [15:0] rom_dout;
    logic [15:0] mem [0:31];
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0] rv;
        logic [4:0] o0, l0, o1, l1;
        logic       att;
        logic [1:0] er, ee;
    } vec_t;
    vec_t tbl [11];

    key_fetch_ctrl_if #(.ADDR_MSB(4)) bus ();

    key_fetch_ctrl #(.ADDR_MSB(4), .MEM_SIZE(20)) dut (
        .mclk       (mclk),
        .reset_n    (reset_n),
        .att_active (att_active),
        .bus        (bus),
        .rom_addr   (rom_addr),
        .rom_cen    (rom_cen),
        .rom_dout   (rom_dout)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) if (!rom_cen) rom_dout <= mem[rom_addr];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge mclk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit model_reject(input logic g, input int off, input int len, input logic att);
        return len == 0 || off + len > 10 || (g && !att);
    endfunction

    // Issues one request from IDLE and follows it to IDLE again, checking every cycle.
    task automatic do_req(input logic [1:0] rv, input logic [4:0] o0, l0, o1, l1,
                          input logic [1:0] er, ee, input bit rnd);
        logic g;
        logic rdy;
        int off, len, stall;
        g   = rv[0] ? 1'b0 : 1'b1;
        off = g ? int'(o1) : int'(o0);
        len = g ? int'(l1) : int'(l0);
        bus.req_valid   = rv;
        bus.req0_offset = o0;
        bus.req0_len    = l0;
        bus.req1_offset = o1;
        bus.req1_len    = l1;
        bus.key_ready   = 2'b00;
        #1;
        check("req_ready accept", bus.req_ready, er);
        check("key_err idle", bus.key_err, 2'b00);
        check("rom_cen idle", rom_cen, 1'b1);
        tick();
        bus.req_valid = 2'b00;
        if (rv == 2'b00) return;
        if (ee != 2'b00) begin
            #1;
            check("key_err pulse", bus.key_err, ee);
            check("rom_cen err", rom_cen, 1'b1);
            check("key_valid err", bus.key_valid, 2'b00);
            tick();
            return;
        end
        for (int i = 0; i < len; i++) begin
            #1;
            check("rom_cen read", rom_cen, 1'b0);
            check("rom_addr read", rom_addr, off + i);
            check("key_valid read", bus.key_valid, 2'b00);
            tick();
            stall = 0;
            forever begin
                rdy = (rnd && stall < 4) ? ($urandom_range(0, 1) == 1) : 1'b1;
                bus.key_ready = rdy ? 2'b01 << g : 2'b00;
                bus.key_ready[!g] = 1'($urandom_range(0, 1));
                #1;
                check("key_valid data", bus.key_valid, 2'b01 << g);
                check("key_data", bus.key_data, mem[off + i]);
                check("key_last", bus.key_last, i == len - 1);
                check("rom_cen data", rom_cen, 1'b1);
                check("req_ready busy", bus.req_ready, 2'b00);
                tick();
                bus.key_ready = 2'b00;
                if (rdy) break;
                stall++;
            end
        end
    endtask

    initial begin
        logic [1:0] rv, er, ee;
        logic [4:0] o0, l0, o1, l1;
        logic g;
        for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
        mem[0] = 16'h0123; mem[1] = 16'h4567; mem[2] = 16'h89ab; mem[3] = 16'hcdef;
        tbl[0]  = '{2'b01, 5'd0,  5'd4,  5'd0, 5'd0, 1'b1, 2'b01, 2'b00};
        tbl[1]  = '{2'b10, 5'd0,  5'd0,  5'd0, 5'd2, 1'b0, 2'b10, 2'b10};
        tbl[2]  = '{2'b10, 5'd0,  5'd0,  5'd8, 5'd3, 1'b1, 2'b10, 2'b10};
        tbl[3]  = '{2'b10, 5'd0,  5'd0,  5'd2, 5'd0, 1'b1, 2'b10, 2'b10};
        tbl[4]  = '{2'b01, 5'd9,  5'd1,  5'd0, 5'd0, 1'b0, 2'b01, 2'b00};
        tbl[5]  = '{2'b01, 5'd8,  5'd24, 5'd0, 5'd0, 1'b1, 2'b01, 2'b01};
        tbl[6]  = '{2'b11, 5'd3,  5'd1,  5'd0, 5'd0, 1'b1, 2'b01, 2'b00};
        tbl[7]  = '{2'b00, 5'd0,  5'd1,  5'd0, 5'd1, 1'b1, 2'b00, 2'b00};
        tbl[8]  = '{2'b10, 5'd0,  5'd0,  5'd6, 5'd4, 1'b1, 2'b10, 2'b00};
        tbl[9]  = '{2'b01, 5'd10, 5'd1,  5'd0, 5'd0, 1'b1, 2'b01, 2'b01};
        tbl[10] = '{2'b10, 5'd0,  5'd0,  5'd1, 5'd3, 1'b1, 2'b10, 2'b00};

        reset_n = 1'b0;
        att_active = 1'b1;
        bus.req_valid = 2'b00;
        bus.req0_offset = '0; bus.req0_len = '0;
        bus.req1_offset = '0; bus.req1_len = '0;
        bus.key_ready = 2'b00;
        tick();
        tick();
        #1;
        check("reset req_ready", bus.req_ready, 2'b00);
        check("reset key_valid", bus.key_valid, 2'b00);
        check("reset key_last", bus.key_last, 1'b0);
        check("reset key_err", bus.key_err, 2'b00);
        check("reset key_data", bus.key_data, 16'h0000);
        check("reset rom_cen", rom_cen, 1'b1);
        check("reset rom_addr", rom_addr, 5'd0);
        reset_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            att_active = tbl[i].att;
            do_req(tbl[i].rv, tbl[i].o0, tbl[i].l0, tbl[i].o1, tbl[i].l1, tbl[i].er, tbl[i].ee, 1'b0);
        end
        att_active = 1'b1;

        // simultaneous requests: requester 1 waits and is taken right after requester 0's last word
        bus.req_valid = 2'b11;
        bus.req0_offset = 5'd0; bus.req0_len = 5'd1;
        bus.req1_offset = 5'd1; bus.req1_len = 5'd1;
        bus.key_ready = 2'b11;
        #1; check("b2b grant0", bus.req_ready, 2'b01); tick();
        bus.req_valid = 2'b10;
        #1; check("b2b busy read", bus.req_ready, 2'b00); tick();
        #1;
        check("b2b valid0", bus.key_valid, 2'b01);
        check("b2b data0", bus.key_data, 16'h0123);
        check("b2b last0", bus.key_last, 1'b1);
        check("b2b busy data", bus.req_ready, 2'b00);
        tick();
        #1; check("b2b grant1", bus.req_ready, 2'b10); tick();
        bus.req_valid = 2'b00;
        #1; check("b2b addr1", rom_addr, 5'd1); tick();
        #1;
        check("b2b valid1", bus.key_valid, 2'b10);
        check("b2b data1", bus.key_data, 16'h4567);
        tick();
        bus.key_ready = 2'b00;

        // attestation region left while the CPU's first word is on the bus
        bus.req_valid = 2'b10;
        bus.req1_offset = 5'd1; bus.req1_len = 5'd3;
        #1; check("abort grant", bus.req_ready, 2'b10); tick();
        bus.req_valid = 2'b00;
        #1; check("abort addr", rom_addr, 5'd1); tick();
        #1; check("abort data before", bus.key_data, 16'h4567);
        att_active = 1'b0;
        #1;
        check("abort valid gated", bus.key_valid, 2'b00);
        check("abort data zero", bus.key_data, 16'h0000);
        tick();
        #1;
        check("abort err", bus.key_err, 2'b10);
        check("abort rom_cen err", rom_cen, 1'b1);
        tick();
        #1;
        check("abort idle err", bus.key_err, 2'b00);
        check("abort idle rom_cen", rom_cen, 1'b1);
        att_active = 1'b1;
        tick();

        // consumer stalls on 89ab for five cycles
        bus.req_valid = 2'b01;
        bus.req0_offset = 5'd2; bus.req0_len = 5'd2;
        #1; check("stall grant", bus.req_ready, 2'b01); tick();
        bus.req_valid = 2'b00;
        tick();
        for (int s = 0; s < 5; s++) begin
            #1;
            check("stall data", bus.key_data, 16'h89ab);
            check("stall rom_cen", rom_cen, 1'b1);
            check("stall valid", bus.key_valid, 2'b01);
            tick();
        end
        bus.key_ready = 2'b01;
        #1; check("stall last0", bus.key_last, 1'b0); tick();
        #1; check("stall addr", rom_addr, 5'd3); tick();
        #1;
        check("stall data2", bus.key_data, 16'hcdef);
        check("stall last", bus.key_last, 1'b1);
        tick();
        bus.key_ready = 2'b00;

        // reset asserted while a word is waiting on the bus
        bus.req_valid = 2'b01;
        bus.req0_offset = 5'd0; bus.req0_len = 5'd4;
        tick();
        bus.req_valid = 2'b00;
        tick();
        #1; check("rst data before", bus.key_data, 16'h0123);
        reset_n = 1'b0;
        tick();
        #1;
        check("rst key_valid", bus.key_valid, 2'b00);
        check("rst key_data", bus.key_data, 16'h0000);
        check("rst key_last", bus.key_last, 1'b0);
        check("rst key_err", bus.key_err, 2'b00);
        check("rst rom_cen", rom_cen, 1'b1);
        reset_n = 1'b1;
        tick();
        do_req(2'b01, 5'd1, 5'd2, 5'd0, 5'd0, 2'b01, 2'b00, 1'b0);

        for (int n = 0; n < 40; n++) begin
            rv = 2'($urandom_range(0, 3));
            o0 = 5'($urandom_range(0, 12)); l0 = 5'($urandom_range(0, 12));
            o1 = 5'($urandom_range(0, 12)); l1 = 5'($urandom_range(0, 12));
            att_active = $urandom_range(0, 3) != 0;
            g  = rv[0] ? 1'b0 : 1'b1;
            er = rv == 2'b00 ? 2'b00 : 2'b01 << g;
            ee = (rv != 2'b00 && model_reject(g, g ? int'(o1) : int'(o0), g ? int'(l1) : int'(l0), att_active))
                 ? 2'b01 << g : 2'b00;
            do_req(rv, o0, l0, o1, l1, er, ee, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
